// File: rtl/aes_session_ctrl.sv
// SPI-framed session controller for an AES core: captures a frame, validates the key
// size, launches the core, waits with a timeout, and holds the result for transmit.
module aes_session_ctrl #(
  parameter int unsigned TIMEOUT = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  input  logic [8:0]   key_len,
  input  logic [127:0] msg_in,
  input  logic [255:0] key_in,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         core_start,
  output logic [127:0] core_msg,
  output logic [255:0] core_key,
  output logic [3:0]   core_nk,
  output logic [3:0]   core_nr,
  output logic [127:0] tx_data,
  output logic         tx_valid,
  output logic         busy,
  output logic [1:0]   err_code
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX     = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_TXWAIT = 3'd5;
  localparam logic [2:0] S_TX     = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_KEYLEN  = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_BUSY    = 2'd3;

  logic [2:0]    state, state_nxt;
  logic          cs_q;
  logic          rise, fall;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          key_ok;
  logic [3:0]    nk_dec, nr_dec;

  logic          core_start_nxt, tx_valid_nxt, busy_nxt;
  logic [127:0]  core_msg_nxt, tx_data_nxt;
  logic [255:0]  core_key_nxt;
  logic [3:0]    core_nk_nxt, core_nr_nxt;
  logic [1:0]    err_nxt;

  // Next-state and next-register-value logic
  always_comb begin
    rise           = cs & ~cs_q;
    fall           = ~cs & cs_q;
    cnt_inc        = cnt + CW'(1);
    state_nxt      = state;
    cnt_nxt        = cnt;
    core_start_nxt = 1'b0;
    core_msg_nxt   = core_msg;
    core_key_nxt   = core_key;
    core_nk_nxt    = core_nk;
    core_nr_nxt    = core_nr;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
    err_nxt        = err_code;
    key_ok         = 1'b1;
    nk_dec         = 4'd4;
    nr_dec         = 4'd10;

    case (key_len)
      9'd128: begin nk_dec = 4'd4; nr_dec = 4'd10; end
      9'd192: begin nk_dec = 4'd6; nr_dec = 4'd12; end
      9'd256: begin nk_dec = 4'd8; nr_dec = 4'd14; end
      default: key_ok = 1'b0;
    endcase

    // A new frame during an operation is flagged but never captured
    if (rise && (state == S_CHECK || state == S_START || state == S_RUN))
      err_nxt = E_BUSY;

    case (state)
      S_IDLE: if (rise) begin state_nxt = S_RX; err_nxt = E_NONE; end
      S_RX:   if (fall) state_nxt = S_CHECK;
      S_CHECK: begin
        if (key_ok) begin
          core_msg_nxt   = msg_in;
          core_key_nxt   = key_in;
          core_nk_nxt    = nk_dec;
          core_nr_nxt    = nr_dec;
          core_start_nxt = 1'b1;
          state_nxt      = S_START;
        end else begin
          err_nxt   = E_KEYLEN;
          state_nxt = S_ERR;
        end
      end
      S_START: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt_inc;
        // Done takes precedence over a timeout expiring in the same cycle
        if (core_done) begin
          tx_data_nxt  = core_result;
          tx_valid_nxt = 1'b1;
          state_nxt    = S_TXWAIT;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          err_nxt      = E_TIMEOUT;
          tx_valid_nxt = 1'b0;
          state_nxt    = S_ERR;
        end
      end
      S_TXWAIT: if (rise) state_nxt = S_TX;
      S_TX: if (fall) begin state_nxt = S_IDLE; tx_valid_nxt = 1'b0; end
      S_ERR: begin
        tx_valid_nxt = 1'b0;
        if (rise) begin state_nxt = S_RX; err_nxt = E_NONE; end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_CHECK) || (state_nxt == S_START) || (state_nxt == S_RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cs_q       <= 1'b0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_msg   <= '0;
      core_key   <= '0;
      core_nk    <= 4'd4;
      core_nr    <= 4'd10;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      err_code   <= E_NONE;
    end else begin
      state      <= state_nxt;
      cs_q       <= cs;
      cnt        <= cnt_nxt;
      core_start <= core_start_nxt;
      core_msg   <= core_msg_nxt;
      core_key   <= core_key_nxt;
      core_nk    <= core_nk_nxt;
      core_nr    <= core_nr_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      busy       <= busy_nxt;
      err_code   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aes_session_ctrl.sv
// Bench for aes_session_ctrl: directed and random SPI sessions checked against a
// session-level reference model.
module tb_aes_session_ctrl;

  localparam int unsigned TO = 300;

  logic         clk, rst, cs, core_done;
  logic [8:0]   key_len;
  logic [127:0] msg_in, core_result;
  logic [255:0] key_in;
  logic         core_start, tx_valid, busy;
  logic [127:0] core_msg, tx_data;
  logic [255:0] core_key;
  logic [3:0]   core_nk, core_nr;
  logic [1:0]   err_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last values the core and transmitter should hold
  logic [127:0] m_msg, m_tx;
  logic [255:0] m_key;
  int           m_nk, m_nr;

  aes_session_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cs(cs), .key_len(key_len), .msg_in(msg_in),
    .key_in(key_in), .core_done(core_done), .core_result(core_result),
    .core_start(core_start), .core_msg(core_msg), .core_key(core_key),
    .core_nk(core_nk), .core_nr(core_nr), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // One full session from IDLE or ERR. Done is offered in RUN cycle delay+1 when that
  // is within the timeout window, otherwise the session is expected to time out.
  task automatic do_session(input string tag, input logic [8:0] kl, input int hold,
                            input int delay, input bit busy_frame);
    logic [127:0] msg, res;
    logic [255:0] key;
    bit           ok;
    int           exp_nk, exp_nr, done_at;
    logic [1:0]   exp_err;
    msg    = rnd128();
    key    = rnd256();
    res    = rnd128();
    ok     = (kl == 9'd128) || (kl == 9'd192) || (kl == 9'd256);
    exp_nk = int'(kl) / 32;
    exp_nr = exp_nk + 6;

    cs = 1'b1; key_len = kl; msg_in = msg; key_in = key;
    tick();
    n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL %s rx_err got %0d exp 0", tag, err_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s rx_busy got %0b exp 0", tag, busy); end
    repeat (hold) tick();
    cs = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s check_busy got %0b exp 1", tag, busy); end
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL %s early_start got %0b exp 0", tag, core_start); end
    n_checks++; if (core_msg !== m_msg) begin n_fail++; $display("FAIL %s msg_before_latch got %0h exp %0h", tag, core_msg, m_msg); end
    tick();

    if (!ok) begin
      n_checks++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL %s keylen_err got %0d exp 1", tag, err_code); end
      n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL %s bad_start got %0b exp 0", tag, core_start); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s err_busy got %0b exp 0", tag, busy); end
      n_checks++; if (core_nk !== 4'(m_nk)) begin n_fail++; $display("FAIL %s nk_kept got %0d exp %0d", tag, core_nk, m_nk); end
      n_checks++; if (core_key !== m_key) begin n_fail++; $display("FAIL %s key_kept got %0h exp %0h", tag, core_key, m_key); end
      return;
    end

    m_msg = msg; m_key = key; m_nk = exp_nk; m_nr = exp_nr;
    n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL %s start got %0b exp 1", tag, core_start); end
    n_checks++; if (core_nk !== 4'(m_nk)) begin n_fail++; $display("FAIL %s nk got %0d exp %0d", tag, core_nk, m_nk); end
    n_checks++; if (core_nr !== 4'(m_nr)) begin n_fail++; $display("FAIL %s nr got %0d exp %0d", tag, core_nr, m_nr); end
    n_checks++; if (core_msg !== m_msg) begin n_fail++; $display("FAIL %s msg got %0h exp %0h", tag, core_msg, m_msg); end
    n_checks++; if (core_key !== m_key) begin n_fail++; $display("FAIL %s key got %0h exp %0h", tag, core_key, m_key); end
    msg_in = rnd128(); key_in = rnd256();
    tick();
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL %s start_pulse got %0b exp 0", tag, core_start); end
    n_checks++; if (core_msg !== m_msg) begin n_fail++; $display("FAIL %s msg_hold got %0h exp %0h", tag, core_msg, m_msg); end

    done_at = (delay + 1 <= int'(TO)) ? delay + 1 : 0;
    exp_err = 2'd0;
    for (int c = 1; c <= int'(TO); c++) begin
      cs = busy_frame && (c == 2);
      if (c == done_at) begin core_done = 1'b1; core_result = res; end
      if (c == int'(TO) && done_at == 0) begin
        n_checks++; if (busy !== 1'b1 || err_code !== exp_err) begin n_fail++; $display("FAIL %s pre_timeout busy %0b err %0d exp 1 %0d", tag, busy, err_code, exp_err); end
      end
      tick();
      core_done = 1'b0;
      if (busy_frame && c == 2) exp_err = 2'd3;
      if (c == done_at) break;
    end
    cs = 1'b0;

    if (done_at == 0) begin
      n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL %s timeout_err got %0d exp 2", tag, err_code); end
      n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s timeout_flags valid %0b busy %0b exp 0 0", tag, tx_valid, busy); end
      return;
    end

    m_tx = res;
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL %s tx_valid got %0b exp 1", tag, tx_valid); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL %s tx_data got %0h exp %0h", tag, tx_data, m_tx); end
    n_checks++; if (err_code !== exp_err) begin n_fail++; $display("FAIL %s done_err got %0d exp %0d", tag, err_code, exp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s done_busy got %0b exp 0", tag, busy); end
    core_done = 1'b1; core_result = ~res;
    tick();
    core_done = 1'b0;
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL %s stray_done got %0h exp %0h", tag, tx_data, m_tx); end
    cs = 1'b1;
    tick();
    tick();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL %s tx_frame_valid got %0b exp 1", tag, tx_valid); end
    cs = 1'b0;
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL %s tx_fall_valid got %0b exp 0", tag, tx_valid); end
    n_checks++; if (tx_data !== m_tx) begin n_fail++; $display("FAIL %s tx_data_kept got %0h exp %0h", tag, tx_data, m_tx); end
  endtask

  task automatic model_reset();
    m_msg = '0; m_key = '0; m_tx = '0; m_nk = 4; m_nr = 10;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; core_done = 1'b1; core_result = rnd128();
    key_len = 9'd256; msg_in = rnd128(); key_in = rnd256();
    tick();
    tick();
    model_reset();
    n_checks++; if (core_start !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset flags start %0b busy %0b valid %0b exp 0 0 0", core_start, busy, tx_valid); end
    n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset err got %0d exp 0", err_code); end
    n_checks++; if (core_msg !== '0 || core_key !== '0 || tx_data !== '0) begin n_fail++; $display("FAIL reset data msg %0h key %0h tx %0h exp 0", core_msg, core_key, tx_data); end
    n_checks++; if (core_nk !== 4'd4 || core_nr !== 4'd10) begin n_fail++; $display("FAIL reset nk_nr got %0d %0d exp 4 10", core_nk, core_nr); end
    rst = 1'b0; cs = 1'b0; core_done = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release busy got %0b exp 0", busy); end
  endtask

  task automatic test_aes256_long();
    do_session("aes256_long", 9'd256, 511, 19, 1'b0);
  endtask

  task automatic test_key_len();
    do_session("aes192", 9'd192, 3, 5, 1'b0);
    do_session("bad_len", 9'd100, 3, 5, 1'b0);
    do_session("after_err", 9'd128, 2, 4, 1'b0);
  endtask

  task automatic test_timeout();
    do_session("timeout", 9'd128, 2, int'(TO), 1'b0);
  endtask

  task automatic test_busy_frame();
    do_session("busy_frame", 9'd256, 2, 10, 1'b1);
  endtask

  task automatic test_done_at_timeout();
    do_session("done_at_timeout", 9'd192, 1, int'(TO) - 1, 1'b0);
  endtask

  task automatic test_reset_in_run();
    cs = 1'b1; key_len = 9'd128; msg_in = rnd128(); key_in = rnd256();
    tick();
    cs = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; core_done = 1'b1; core_result = rnd128();
    tick();
    core_done = 1'b0;
    model_reset();
    n_checks++; if (tx_valid !== 1'b0 || tx_data !== m_tx) begin n_fail++; $display("FAIL rst_run tx valid %0b data %0h exp 0 0", tx_valid, tx_data); end
    n_checks++; if (busy !== 1'b0 || core_start !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL rst_run flags busy %0b start %0b err %0d exp 0 0 0", busy, core_start, err_code); end
    n_checks++; if (core_msg !== m_msg || core_nk !== 4'(m_nk)) begin n_fail++; $display("FAIL rst_run core msg %0h nk %0d exp 0 4", core_msg, core_nk); end
    tick();
    n_checks++; if (core_start !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run_late start %0b valid %0b exp 0 0", core_start, tx_valid); end
  endtask

  task automatic test_random();
    logic [8:0] kl;
    int         sel, delay;
    bit         bf;
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 2)      kl = 9'd128;
      else if (sel < 4) kl = 9'd192;
      else if (sel < 6) kl = 9'd256;
      else begin
        kl = 9'($urandom_range(0, 511));
        while (kl == 9'd128 || kl == 9'd192 || kl == 9'd256) kl = 9'($urandom_range(0, 511));
      end
      delay = int'($urandom_range(0, 40));
      bf = (delay >= 3) && ($urandom_range(0, 3) == 0);
      do_session("random", kl, int'($urandom_range(0, 6)), delay, bf);
    end
  endtask

  task automatic test_back_to_back();
    do_session("b2b_a", 9'd128, 0, 0, 1'b0);
    do_session("b2b_b", 9'd256, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; core_done = 1'b0; key_len = '0;
    msg_in = '0; key_in = '0; core_result = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_aes256_long();
    test_key_len();
    test_timeout();
    test_busy_frame();
    test_reset_in_run();
    test_done_at_timeout();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
